// File: rtl/pipelined_add_sub.sv
// Pipelined carry-ripple adder/subtractor: Width bits split into Stages equal chunks,
// one chunk ripple per stage, with a global-enable valid/ready handshake.
module pipelined_add_sub #(
    parameter int unsigned Width  = 32,
    parameter int unsigned Stages = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] add1_i,
    input  logic [Width-1:0] add2_i,
    input  logic             carry_i,
    input  logic             sub_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [Width-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int unsigned CW = Width / Stages;

    if ((Stages < 1) || ((Width % Stages) != 0)) begin : g_bad_params
        $error("pipelined_add_sub: Stages must be >= 1 and divide Width");
    end

    // Each stage carries the full operand/sum words; chunks not yet consumed act as
    // the skew registers, chunks already produced act as the deskew registers.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             overflow;
        logic [Width-1:0] a;
        logic [Width-1:0] b;
        logic [Width-1:0] sum;
    } stage_t;

    stage_t stage_q [Stages];
    stage_t stage_d [Stages];
    stage_t in_beat;
    logic   en;

    // Ripple chunk k of src; the carry into the chunk MSB is kept for overflow.
    function automatic stage_t advance(input stage_t src, input int unsigned k);
        stage_t dst;
        logic   c;
        logic   c_msb;
        dst   = src;
        c     = src.carry;
        c_msb = src.carry;
        for (int unsigned i = 0; i < CW; i++) begin
            dst.sum[k*CW+i] = src.a[k*CW+i] ^ src.b[k*CW+i] ^ c;
            if (i == CW - 1) c_msb = c;
            c = (src.a[k*CW+i] & src.b[k*CW+i]) | (c & (src.a[k*CW+i] ^ src.b[k*CW+i]));
        end
        dst.carry    = c;
        dst.overflow = c ^ c_msb;
        return dst;
    endfunction

    assign en      = ready_i | ~stage_q[Stages-1].valid;
    assign ready_o = en;

    always_comb begin
        in_beat.valid    = valid_i;
        in_beat.carry    = carry_i ^ sub_i;
        in_beat.overflow = 1'b0;
        in_beat.a        = add1_i;
        in_beat.b        = sub_i ? ~add2_i : add2_i;
        in_beat.sum      = '0;
    end

    always_comb begin
        // NOTE: every stage defaults to holding its value, so no path leaves stage_d
        // unassigned and no latch is inferred when en is low.
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = advance(in_beat, 0);
            for (int unsigned k = 1; k < Stages; k++) begin
                stage_d[k] = advance(stage_q[k-1], k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: data registers are reset as well as valid bits, so the outputs read
            // zero during and after reset rather than stale or X data.
            for (int unsigned k = 0; k < Stages; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignment so every stage samples its predecessor's
            // pre-edge value; blocking here would collapse the pipeline.
            stage_q <= stage_d;
        end
    end

    assign sum_o      = stage_q[Stages-1].sum;
    assign carry_o    = stage_q[Stages-1].carry;
    assign overflow_o = stage_q[Stages-1].overflow;
    assign valid_o    = stage_q[Stages-1].valid;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed self-checking bench for pipelined_add_sub (Width=32, Stages=4).
module tb_pipelined_add_sub;

    localparam int W   = 32;
    localparam int S   = 4;
    localparam int NBP = 10;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [W-1:0] add1_i;
    logic [W-1:0] add2_i;
    logic         carry_i;
    logic         sub_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] sum_o;
    logic         carry_o;
    logic         overflow_o;
    logic         valid_o;
    logic         ready_i;

    int tests_run    = 0;
    int tests_failed = 0;

    pipelined_add_sub #(.Width(W), .Stages(S)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .add1_i     (add1_i),
        .add2_i     (add2_i),
        .carry_i    (carry_i),
        .sub_i      (sub_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .sum_o      (sum_o),
        .carry_o    (carry_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference: {overflow, carry, sum} of a + b' + cin, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic         ovf;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, cin ^ sub};
        ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    // Sends one beat and reports what the output looks like one edge before and at the
    // expected arrival edge (acceptance edge counted as the first of S edges).
    task automatic send_single(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic cin,
                               output logic early_v, output logic v, output logic [W-1:0] s,
                               output logic c, output logic o);
        @(posedge clk_i);
        #1;
        add1_i = a; add2_i = b; sub_i = sub; carry_i = cin; valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (S - 2) @(posedge clk_i);
        @(negedge clk_i);
        early_v = valid_o;
        @(posedge clk_i);
        @(negedge clk_i);
        v = valid_o; s = sum_o; c = carry_o; o = overflow_o;
    endtask

    task automatic test_reset();
        logic ev, v, c, o;
        logic [W-1:0] s;
        ready_i = 1'b0;
        send_single(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, ev, v, s, c, o);
        tests_run++;
        if ({v, s, c, o} !== {1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_preload: got v=%b s=%h c=%b o=%b expected 1 7fffffff 1 1", v, s, c, o);
        end
        #2 rst_ni = 1'b0;
        #1;
        tests_run++;
        if ({valid_o, sum_o, carry_o, overflow_o} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_async_clear: got v=%b s=%h c=%b o=%b expected all 0",
                     valid_o, sum_o, carry_o, overflow_o);
        end
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", ready_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held: got ready=%b valid=%b expected 1 0", ready_o, valid_o);
        end
        ready_i = 1'b1;
        rst_ni  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            tests_run++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_idle_%0d: got valid=%b ready=%b expected 0 1", i, valid_o, ready_o);
            end
        end
    endtask

    task automatic test_carry_chain();
        logic ev, v, c, o;
        logic [W-1:0] s;
        ready_i = 1'b1;
        send_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, ev, v, s, c, o);
        tests_run++;
        if (ev !== 1'b0) begin
            tests_failed++;
            $display("FAIL carry_chain_early: got valid=%b one edge early, expected 0", ev);
        end
        tests_run++;
        if ({v, s, c, o} !== {1'b1, 32'h0000_0000, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL carry_chain: got v=%b s=%h c=%b o=%b expected 1 00000000 1 0", v, s, c, o);
        end
    endtask

    task automatic test_sub_overflow();
        logic ev, v, c, o;
        logic [W-1:0] s;
        send_single(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, ev, v, s, c, o);
        tests_run++;
        if ({ev, v, s, c, o} !== {1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL sub_overflow: got ev=%b v=%b s=%h c=%b o=%b expected 0 1 7fffffff 1 1",
                     ev, v, s, c, o);
        end
    endtask

    task automatic test_borrow_in();
        logic ev, v, c, o;
        logic [W-1:0] s;
        send_single(32'd5, 32'd3, 1'b1, 1'b1, ev, v, s, c, o);
        tests_run++;
        if ({ev, v, s, c, o} !== {1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL borrow_in: got ev=%b v=%b s=%h c=%b o=%b expected 0 1 00000001 1 0",
                     ev, v, s, c, o);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a_t [16];
        logic [W-1:0] b_t [16];
        logic         s_t [16];
        logic         c_t [16];
        logic [W+1:0] exp_v;
        for (int i = 0; i < 16; i++) begin
            a_t[i] = $urandom; b_t[i] = $urandom;
            s_t[i] = 1'($urandom_range(1)); c_t[i] = 1'($urandom_range(1));
        end
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 16 + S + 3; cyc++) begin
            @(posedge clk_i);
            #1;
            if (cyc < 16) begin
                add1_i = a_t[cyc]; add2_i = b_t[cyc]; sub_i = s_t[cyc]; carry_i = c_t[cyc];
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            tests_run++;
            if (cyc >= S && cyc < 16 + S) begin
                exp_v = model(a_t[cyc-S], b_t[cyc-S], s_t[cyc-S], c_t[cyc-S]);
                if ({valid_o, overflow_o, carry_o, sum_o} !== {1'b1, exp_v}) begin
                    tests_failed++;
                    $display("FAIL stream_beat_%0d: got v=%b o=%b c=%b s=%h expected 1 %b %b %h",
                             cyc - S, valid_o, overflow_o, carry_o, sum_o,
                             exp_v[W+1], exp_v[W], exp_v[W-1:0]);
                end
            end else if (valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL stream_idle_cyc%0d: got valid=%b expected 0", cyc, valid_o);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a_t [NBP];
        logic [W-1:0] b_t [NBP];
        logic         s_t [NBP];
        logic [W+1:0] exp_v;
        logic [W-1:0] snap_s;
        logic         snap_c, snap_o;
        int in_idx  = 0;
        int out_idx = 0;
        for (int i = 0; i < NBP; i++) begin
            a_t[i] = 32'h1111_1111 * i + 32'hF000_0000;
            b_t[i] = 32'h0FFF_FFF0 + i;
            s_t[i] = i[0];
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk_i);
            #1;
            ready_i = !(cyc >= 6 && cyc <= 8);
            if (in_idx < NBP) begin
                add1_i = a_t[in_idx]; add2_i = b_t[in_idx]; sub_i = s_t[in_idx]; carry_i = 1'b0;
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (cyc >= 6 && cyc <= 8) begin
                tests_run++;
                if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_ready_cyc%0d: got valid=%b ready=%b expected 1 0",
                             cyc, valid_o, ready_o);
                end
                if (cyc == 6) begin
                    snap_s = sum_o; snap_c = carry_o; snap_o = overflow_o;
                end else begin
                    tests_run++;
                    if ({sum_o, carry_o, overflow_o} !== {snap_s, snap_c, snap_o}) begin
                        tests_failed++;
                        $display("FAIL stall_hold_cyc%0d: got s=%h c=%b o=%b expected %h %b %b",
                                 cyc, sum_o, carry_o, overflow_o, snap_s, snap_c, snap_o);
                    end
                end
            end
            if (valid_o === 1'b1 && ready_i) begin
                tests_run++;
                if (out_idx >= NBP) begin
                    tests_failed++;
                    $display("FAIL bp_extra_beat: got beat %0d expected at most %0d", out_idx, NBP);
                end else begin
                    exp_v = model(a_t[out_idx], b_t[out_idx], s_t[out_idx], 1'b0);
                    if ({overflow_o, carry_o, sum_o} !== exp_v) begin
                        tests_failed++;
                        $display("FAIL bp_beat_%0d: got o=%b c=%b s=%h expected %b %b %h", out_idx,
                                 overflow_o, carry_o, sum_o, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
                    end
                end
                out_idx++;
            end
            if (valid_i && ready_o === 1'b1) in_idx++;
        end
        tests_run++;
        if (out_idx != NBP) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d beats expected %0d", out_idx, NBP);
        end
        ready_i = 1'b1;
    endtask

    task automatic test_midflight_reset();
        logic ev, v, c, o;
        logic [W-1:0] s;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            add1_i = 32'h100 * (i + 1); add2_i = 32'h1; sub_i = 1'b0; carry_i = 1'b0; valid_i = 1'b1;
        end
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            tests_run++;
            if (valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_stale_%0d: got valid=%b expected 0", i, valid_o);
            end
        end
        send_single(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, ev, v, s, c, o);
        tests_run++;
        if ({ev, v, s, c, o} !== {1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midreset_first_beat: got ev=%b v=%b s=%h c=%b o=%b expected 0 1 2345678a 0 0",
                     ev, v, s, c, o);
        end
    endtask

    initial begin
        rst_ni = 1'b0; add1_i = '0; add2_i = '0; carry_i = 1'b0; sub_i = 1'b0;
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        test_reset();
        test_carry_chain();
        test_sub_overflow();
        test_borrow_in();
        test_back_to_back();
        test_backpressure();
        test_midflight_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
